sat_accumulator: RTL and testbench

Parametrised, pipelined signed accumulator with selectable saturating or wrapping arithmetic and add/subtract mode. It is the sequential successor to the team's combinational saturating adder. It accumulates a stream of signed samples into a running total and reports sticky overflow and a sample count. It sits in datapaths that sum signed samples, such as filter taps, energy or DC estimates and statistics, where wrap-around would corrupt the result.

---
 rtl/sat_accumulator_pkg.sv | 16 +
 rtl/sat_accumulator_if.sv | 26 ++
 rtl/sat_add_sub.sv | 34 +++
 rtl/sat_accumulator.sv | 95 +++++++++
 tb/tb_sat_accumulator.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/sat_accumulator_pkg.sv
// Shared constants and helpers for the saturating accumulator and its add/sub unit.
package sat_accum_pkg;

  localparam int MODE_SUB  = 0;
  localparam int MODE_WRAP = 1;

  // Bit patterns of the N-bit signed extremes, returned in 64 bits; callers take [N-1:0].
  function automatic logic [63:0] sat_max(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int n);
    return 64'd1 << (n - 1);
  endfunction

endpackage

// File: rtl/sat_accumulator_if.sv
// Sample stream in, accumulated result and status out.
// No backpressure: in_valid qualifies in_data/mode in the cycle it is high; out_valid is a one-cycle pulse.
interface sat_accumulator_if #(
  parameter int N     = 8,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic [N-1:0]     in_data;
  logic [1:0]       mode;
  logic             clear;
  logic [N-1:0]     out;
  logic             out_valid;
  logic             ovf;
  logic             ovf_sticky;
  logic [CNT_W-1:0] sample_cnt;

  modport master (
    output in_valid, in_data, mode, clear,
    input  out, out_valid, ovf, ovf_sticky, sample_cnt
  );

  modport slave (
    input  in_valid, in_data, mode, clear,
    output out, out_valid, ovf, ovf_sticky, sample_cnt
  );
endinterface

// File: rtl/sat_add_sub.sv
// Combinational N-bit signed add/subtract with overflow flag and saturate-or-wrap result.
module sat_add_sub
  import sat_accum_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  input  logic         wrap,
  output logic [N-1:0] result,
  output logic         ovf
);
  localparam logic [63:0] MAX_W = sat_max(N);
  localparam logic [63:0] MIN_W = sat_min(N);

  logic [N:0] a_ext;
  logic [N:0] b_ext;
  logic [N:0] r;

  assign a_ext = {a[N-1], a};
  assign b_ext = {b[N-1], b};
  assign r     = sub ? (a_ext - b_ext) : (a_ext + b_ext);

  // Extra sign bit disagreeing with the N-bit sign means the true result left the N-bit range.
  assign ovf = r[N] ^ r[N-1];

  always_comb begin
    result = r[N-1:0];
    if (ovf && !wrap) begin
      result = r[N] ? MIN_W[N-1:0] : MAX_W[N-1:0];
    end
  end
endmodule

// File: rtl/sat_accumulator.sv
// Two-stage signed accumulator: stage 1 registers the sample, stage 2 folds it into the total.
module sat_accumulator
  import sat_accum_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  sat_accumulator_if.slave  bus
);
  logic             s1_valid_q;
  logic [N-1:0]     s1_data_q;
  logic [1:0]       s1_mode_q;

  logic [N-1:0]     acc_q,        acc_d;
  logic             out_valid_q,  out_valid_d;
  logic             ovf_q,        ovf_d;
  logic             sticky_q,     sticky_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;

  logic [N-1:0]     acc_base;
  logic [N-1:0]     sum_result;
  logic             sum_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= '0;
    end else begin
      s1_valid_q <= bus.in_valid;
      s1_data_q  <= bus.in_data;
      s1_mode_q  <= bus.mode;
    end
  end

  // A coincident clear makes the stage-1 sample start from an empty accumulator.
  assign acc_base = bus.clear ? '0 : acc_q;

  sat_add_sub #(.N(N)) u_add_sub (
    .a      (acc_base),
    .b      (s1_data_q),
    .sub    (s1_mode_q[MODE_SUB]),
    .wrap   (s1_mode_q[MODE_WRAP]),
    .result (sum_result),
    .ovf    (sum_ovf)
  );

  always_comb begin
    acc_d       = acc_q;
    out_valid_d = 1'b0;
    ovf_d       = 1'b0;
    sticky_d    = sticky_q;
    cnt_d       = cnt_q;
    if (bus.clear) begin
      acc_d    = '0;
      sticky_d = 1'b0;
      cnt_d    = '0;
    end
    if (s1_valid_q) begin
      acc_d       = sum_result;
      out_valid_d = 1'b1;
      ovf_d       = sum_ovf;
      sticky_d    = (bus.clear ? 1'b0 : sticky_q) | sum_ovf;
      if (bus.clear) begin
        cnt_d = CNT_W'(1);
      end else if (!(&cnt_q)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.out        = acc_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.ovf        = ovf_q;
  assign bus.ovf_sticky = sticky_q;
  assign bus.sample_cnt = cnt_q;
endmodule

// File: tb/tb_sat_accumulator.sv
// Directed bench for sat_accumulator: a CNT_W=8 instance plus a CNT_W=2 twin fed the same stream.
module tb_sat_accumulator;
  localparam int N = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  sat_accumulator_if #(.N(N), .CNT_W(8)) u_if ();
  sat_accumulator_if #(.N(N), .CNT_W(2)) u_if2 ();

  assign u_if2.in_valid = u_if.in_valid;
  assign u_if2.in_data  = u_if.in_data;
  assign u_if2.mode     = u_if.mode;
  assign u_if2.clear    = u_if.clear;

  sat_accumulator #(.N(N), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  sat_accumulator #(.N(N), .CNT_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (u_if2.slave)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] s8(input int v);
    logic [31:0] t;
    t = v;
    return {24'd0, t[7:0]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_res(input string tag, input int e_out, input logic e_valid,
                           input logic e_ovf, input logic e_sticky, input int e_cnt);
    check_eq({tag, ".out"},        32'(u_if.out),        s8(e_out));
    check_eq({tag, ".out_valid"},  32'(u_if.out_valid),  32'(e_valid));
    check_eq({tag, ".ovf"},        32'(u_if.ovf),        32'(e_ovf));
    check_eq({tag, ".ovf_sticky"}, 32'(u_if.ovf_sticky), 32'(e_sticky));
    check_eq({tag, ".sample_cnt"}, 32'(u_if.sample_cnt), e_cnt);
  endtask

  // driver tasks
  task automatic drive(input logic v, input int d, input logic [1:0] m, input logic c);
    logic [31:0] t;
    t = d;
    u_if.in_valid = v;
    u_if.in_data  = t[N-1:0];
    u_if.mode     = m;
    u_if.clear    = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 0, 2'b00, 1'b0);
  endtask

  task automatic clear_idle();
    drive(1'b0, 0, 2'b00, 1'b1);
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    idle();
    tick();
    tick();
    check_res("reset", 0, 1'b0, 1'b0, 1'b0, 0);
    rst = 1'b0;

    // saturate add 100, 50
    drive(1'b1, 100, 2'b00, 1'b0); tick();
    check_eq("sat_add.lat1", 32'(u_if.out_valid), 32'd0);
    drive(1'b1, 50, 2'b00, 1'b0);  tick();
    check_res("sat_add.s1", 100, 1'b1, 1'b0, 1'b0, 1);
    idle(); tick();
    check_res("sat_add.s2", 127, 1'b1, 1'b1, 1'b1, 2);
    tick();
    check_res("sat_add.hold", 127, 1'b0, 1'b0, 1'b1, 2);

    // clear alone on an idle cycle
    clear_idle();
    check_res("clear_idle", 0, 1'b0, 1'b0, 1'b0, 0);

    // saturate add negatives
    drive(1'b1, -100, 2'b00, 1'b0); tick();
    drive(1'b1, -50, 2'b00, 1'b0);  tick();
    check_res("sat_neg.s1", -100, 1'b1, 1'b0, 1'b0, 1);
    idle(); tick();
    check_res("sat_neg.s2", -128, 1'b1, 1'b1, 1'b1, 2);

    // wrap add
    clear_idle();
    drive(1'b1, 100, 2'b10, 1'b0); tick();
    drive(1'b1, 50, 2'b10, 1'b0);  tick();
    check_res("wrap_add.s1", 100, 1'b1, 1'b0, 1'b0, 1);
    idle(); tick();
    check_res("wrap_add.s2", -106, 1'b1, 1'b1, 1'b1, 2);

    // 0 - (-128), saturate then wrap
    clear_idle();
    drive(1'b1, -128, 2'b01, 1'b0); tick();
    idle(); tick();
    check_res("sub_min_sat", 127, 1'b1, 1'b1, 1'b1, 1);
    clear_idle();
    drive(1'b1, -128, 2'b11, 1'b0); tick();
    idle(); tick();
    check_res("sub_min_wrap", -128, 1'b1, 1'b1, 1'b1, 1);

    // per-sample modes: +10 then -3
    clear_idle();
    drive(1'b1, 10, 2'b00, 1'b0); tick();
    drive(1'b1, 3, 2'b01, 1'b0);  tick();
    check_res("mixed.s1", 10, 1'b1, 1'b0, 1'b0, 1);
    idle(); tick();
    check_res("mixed.s2", 7, 1'b1, 1'b0, 1'b0, 2);

    // reach 90 with sticky set, then clear coincident with sample 20
    clear_idle();
    drive(1'b1, 100, 2'b00, 1'b0); tick();
    drive(1'b1, 100, 2'b00, 1'b0); tick();
    check_res("pre_clr.s1", 100, 1'b1, 1'b0, 1'b0, 1);
    drive(1'b1, -37, 2'b00, 1'b0); tick();
    check_res("pre_clr.s2", 127, 1'b1, 1'b1, 1'b1, 2);
    drive(1'b1, 20, 2'b00, 1'b0);  tick();
    check_res("pre_clr.s3", 90, 1'b1, 1'b0, 1'b1, 3);
    drive(1'b0, 0, 2'b00, 1'b1);   tick();
    check_res("clr_coinc", 20, 1'b1, 1'b0, 1'b0, 1);

    // reset with two samples in flight
    drive(1'b1, 7, 2'b00, 1'b0); tick();
    drive(1'b1, 9, 2'b00, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    check_res("rst_flight.a", 0, 1'b0, 1'b0, 1'b0, 0);
    tick();
    check_res("rst_flight.b", 0, 1'b0, 1'b0, 1'b0, 0);
    drive(1'b1, 5, 2'b00, 1'b0); tick();
    check_eq("post_rst.lat1", 32'(u_if.out_valid), 32'd0);
    idle(); tick();
    check_res("post_rst", 5, 1'b1, 1'b0, 1'b0, 1);

    // six back-to-back samples of 1; CNT_W=2 twin saturates at 3
    clear_idle();
    for (int i = 0; i <= 6; i++) begin
      drive((i < 6) ? 1'b1 : 1'b0, 1, 2'b00, 1'b0);
      tick();
      if (i >= 1) begin
        check_res($sformatf("burst%0d", i), i, 1'b1, 1'b0, 1'b0, i);
        check_eq($sformatf("burst%0d.cnt2", i), 32'(u_if2.sample_cnt), (i > 3) ? 32'd3 : 32'(i));
        check_eq($sformatf("burst%0d.out2", i), 32'(u_if2.out), s8(i));
        check_eq($sformatf("burst%0d.valid2", i), 32'(u_if2.out_valid), 32'd1);
      end
    end
    tick();
    check_eq("burst.end_valid", 32'(u_if.out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
